// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage. It keeps a single PC and issues one instruction
// memory request at a time, then writes the returned word into the IF/ID
// pipeline register. The decode stage can stall the fetch, and it can
// redirect the fetch to a new PC.
//
// States:
//   REQ  - request is presented until it is granted.
//   WAIT - one granted request is outstanding.
//   HOLD - a response arrived during a stall and is parked.
//   HALT - a misaligned redirect was trapped; only reset leaves this state.
//
// Ports:
//   clk, rst_n            clock; synchronous active-low reset
//   stall                 freezes IF/ID and PC; a redirect is ignored
//   takeBranch, branch_PC redirect request and its target
//   imem_req, imem_addr   memory request and address (address = PC)
//   imem_gnt              the memory accepts the request this cycle
//   imem_valid, imem_rdata  response strobe and instruction word
//   instruction_IFID_out, PC_IFID_out, PC_plus4_IFID_out, valid_IFID_out
//                         IF/ID pipeline register
//   fetch_count           number of valid IF/ID loads (wraps modulo 2^32)
//   fetch_fault           sticky misaligned-redirect fault
//
// Build option:
//   FETCH_MISALIGN_TRAP_EN - when this macro is defined, a redirect to an
//   address with non-zero bits [1:0] sets fetch_fault and halts the fetch.
//   When it is undefined, the low two bits of the target are cleared.
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        takeBranch,
  input  logic [31:0] branch_PC,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction_IFID_out,
  output logic [31:0] PC_IFID_out,
  output logic [31:0] PC_plus4_IFID_out,
  output logic        valid_IFID_out,
  output logic [31:0] fetch_count,
  output logic        fetch_fault
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_HALT = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic        drop_reg, drop_next;
  logic [31:0] hold_reg, hold_next;
  logic [31:0] instr_reg, instr_next;
  logic [31:0] pc_ifid_reg, pc_ifid_next;
  logic [31:0] pc4_ifid_reg, pc4_ifid_next;
  logic        valid_reg, valid_next;
  logic [31:0] count_reg, count_next;

  logic        accept_redirect;
  logic        misaligned;
  logic [31:0] redirect_pc;
  logic        load_en;
  logic [31:0] load_word;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic fault_reg, fault_next;

  assign redirect_pc = branch_PC;
  assign misaligned  = |branch_PC[1:0];
  assign fetch_fault = fault_reg;

  // The fault flag is sticky. Once it is set, the FSM is in HALT and
  // ignores any further redirect, so only reset can clear the flag.
  assign fault_next = fault_reg | (accept_redirect & misaligned);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fault_reg <= 1'b0;
    end else begin
      fault_reg <= fault_next;
    end
  end
`else
  logic [1:0] unused_pc_lsbs;

  assign redirect_pc    = {branch_PC[31:2], 2'b00};
  assign misaligned     = 1'b0;
  assign unused_pc_lsbs = branch_PC[1:0];
  assign fetch_fault    = 1'b0;
`endif

  // The request is gated with rst_n, so the memory never sees a request
  // while the unit is held in reset.
  assign imem_req  = rst_n && (state_reg == S_REQ);
  assign imem_addr = pc_reg;

  // A redirect is taken only when decode is not stalling and the unit is
  // not halted.
  assign accept_redirect = takeBranch && !stall && (state_reg != S_HALT);

  assign instruction_IFID_out = instr_reg;
  assign PC_IFID_out          = pc_ifid_reg;
  assign PC_plus4_IFID_out    = pc4_ifid_reg;
  assign valid_IFID_out       = valid_reg;
  assign fetch_count          = count_reg;

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    drop_next     = drop_reg;
    hold_next     = hold_reg;
    instr_next    = instr_reg;
    pc_ifid_next  = pc_ifid_reg;
    pc4_ifid_next = pc4_ifid_reg;
    valid_next    = valid_reg;
    count_next    = count_reg;
    load_en       = 1'b0;
    load_word     = hold_reg;

    if (state_reg == S_HALT) begin
      // HALT issues no requests and drops any late response.
      if (!stall) begin
        instr_next = NOP;
        valid_next = 1'b0;
      end
    end else if (accept_redirect) begin
      pc_next    = redirect_pc;
      instr_next = NOP;
      valid_next = 1'b0;
      // A request can still be in flight after the redirect. That happens
      // when the unit is in WAIT and has no response this cycle, or when a
      // grant lands in this same cycle. Its response belongs to the old
      // path, so it must be dropped when it arrives. A response that
      // arrives in this cycle is simply not loaded. A parked word in HOLD
      // is discarded by going back to REQ.
      if ((state_reg == S_WAIT && !imem_valid) ||
          (state_reg == S_REQ && imem_gnt)) begin
        state_next = S_WAIT;
        drop_next  = 1'b1;
      end else begin
        state_next = S_REQ;
        drop_next  = 1'b0;
      end
      if (misaligned) begin
        state_next = S_HALT;
        drop_next  = 1'b0;
      end
    end else begin
      case (state_reg)
        S_REQ: begin
          if (imem_gnt) begin
            state_next = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_valid) begin
            if (drop_reg) begin
              drop_next  = 1'b0;
              state_next = S_REQ;
            end else if (stall) begin
              hold_next  = imem_rdata;
              state_next = S_HOLD;
            end else begin
              load_en   = 1'b1;
              load_word = imem_rdata;
            end
          end
        end
        S_HOLD: begin
          if (!stall) begin
            load_en = 1'b1;
          end
        end
        default: begin
          state_next = state_reg;
        end
      endcase

      if (load_en) begin
        instr_next    = load_word;
        pc_ifid_next  = pc_reg;
        pc4_ifid_next = pc_reg + 32'd4;
        valid_next    = 1'b1;
        pc_next       = pc_reg + 32'd4;
        count_next    = count_reg + 32'd1;
        state_next    = S_REQ;
      end else if (!stall) begin
        // When no new word is loaded, the stage emits a bubble.
        instr_next = NOP;
        valid_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= S_REQ;
      pc_reg       <= RESET_PC;
      drop_reg     <= 1'b0;
      hold_reg     <= NOP;
      instr_reg    <= NOP;
      pc_ifid_reg  <= 32'h0000_0000;
      pc4_ifid_reg <= 32'h0000_0000;
      valid_reg    <= 1'b0;
      count_reg    <= 32'h0000_0000;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      drop_reg     <= drop_next;
      hold_reg     <= hold_next;
      instr_reg    <= instr_next;
      pc_ifid_reg  <= pc_ifid_next;
      pc4_ifid_reg <= pc4_ifid_next;
      valid_reg    <= valid_next;
      count_reg    <= count_next;
    end
  end

endmodule
